dm_access_unit: RTL and testbench

//   Load/store front-end between the datapath and the 512x32 word-addressed data memory.

---
 rtl/dm_access_unit.sv | 150 +++++++++++++++
 tb/tb_dm_access_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// Load/store front-end for a word-addressed data memory: sub-word load extraction,
// read-modify-write for sub-word stores, and misalignment/illegal-size rejection.
module dm_access_unit #(
    parameter int AW = 9
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          REQ_WE,
    input  logic [1:0]    REQ_SIZE,
    input  logic          REQ_SIGNED,
    input  logic [AW+1:0] REQ_ADDR,
    input  logic [31:0]   REQ_WDATA,
    output logic          RSP_VALID,
    output logic [31:0]   RSP_RDATA,
    output logic          RSP_ERR,
    output logic [AW-1:0] DMA,
    output logic [1:0]    DMWE,
    output logic [31:0]   DMWD,
    input  logic [31:0]   DMRD
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_RESP,
        S_ERR
    } state_t;

    state_t          r_state;
    logic [AW+1:0]   r_addr;
    logic [1:0]      r_size;
    logic            r_signed;
    logic [31:0]     r_wword;
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [31:0]     r_rsp_rdata;

    logic            w_accept;
    logic            w_req_err;
    logic [7:0]      w_lane [4];
    logic [3:0]      w_be;
    logic [31:0]     w_wrep;
    logic [31:0]     w_merged;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;

    assign REQ_READY = (r_state == S_IDLE) & ~RST;
    assign w_accept  = REQ_VALID & REQ_READY;

    assign w_req_err = (REQ_SIZE == 2'b11)
                     | ((REQ_SIZE == 2'b01) & REQ_ADDR[0])
                     | ((REQ_SIZE == 2'b10) & (REQ_ADDR[1:0] != 2'b00));

    // Store data replicated across all lanes so each lane only needs a keep/replace mux.
    assign w_wrep = (r_size == 2'b00) ? {4{r_wword[7:0]}} : {2{r_wword[15:0]}};

    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            2'b00:   w_be[r_addr[1:0]] = 1'b1;
            2'b01:   w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi]          = DMRD[8*gi +: 8];
            assign w_merged[8*gi +: 8] = w_be[gi] ? w_wrep[8*gi +: 8] : w_lane[gi];
        end
    endgenerate

    assign w_byte = w_lane[r_addr[1:0]];
    assign w_half = r_addr[1] ? DMRD[31:16] : DMRD[15:0];

    always_comb begin
        case (r_size)
            2'b00:   w_load = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
            2'b01:   w_load = r_signed ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
            default: w_load = DMRD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_wword     <= 32'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= REQ_ADDR;
                        r_size   <= REQ_SIZE;
                        r_signed <= REQ_SIGNED;
                        r_wword  <= REQ_WDATA;
                        if (w_req_err) begin
                            r_state     <= S_ERR;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (!REQ_WE) begin
                            r_state <= S_LOAD;
                        end else if (REQ_SIZE == 2'b10) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_MERGE;
                        end
                    end
                end
                S_LOAD: begin
                    r_rsp_rdata <= w_load;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_MERGE: begin
                    r_wword <= w_merged;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write strobe is gated by reset so an aborted request never reaches memory.
    assign DMWE      = ((r_state == S_WRITE) && !RST) ? 2'b01 : 2'b00;
    assign DMWD      = (r_state == S_WRITE) ? r_wword : 32'b0;
    assign DMA       = r_addr[AW+1:2];
    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rsp_rdata;
    assign RSP_ERR   = r_rsp_err;

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit: a reference memory model predicts responses
// and memory writes, which monitors compare against the DUT as they appear.
module tb_dm_access_unit;

    localparam int AW = 9;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WE;
    logic [1:0]    REQ_SIZE;
    logic          REQ_SIGNED;
    logic [AW+1:0] REQ_ADDR;
    logic [31:0]   REQ_WDATA;
    logic          RSP_VALID;
    logic [31:0]   RSP_RDATA;
    logic          RSP_ERR;
    logic [AW-1:0] DMA;
    logic [1:0]    DMWE;
    logic [31:0]   DMWD;
    logic [31:0]   DMRD;

    dm_access_unit #(.AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .DMA(DMA), .DMWE(DMWE), .DMWD(DMWD), .DMRD(DMRD)
    );

    always #5 CLK = ~CLK;

    // Data memory, with a backdoor port used only for preloading.
    logic [31:0]   mem [512];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [31:0]   bd_data = '0;
    assign DMRD = mem[DMA];
    always @(posedge CLK) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (DMWE == 2'b01) mem[DMA] <= DMWD;
    end

    logic [31:0] ref_mem [512];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } rsp_t;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    rsp_t rq[$];
    wr_t  wq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic sgn,
                                           input logic [AW+1:0] addr);
        logic [31:0] w;
        logic [31:0] sh;
        w  = ref_mem[addr[AW+1:2]];
        sh = w >> {addr[1:0], 3'b000};
        case (size)
            2'b00:   return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
            2'b01:   return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic void m_store(input logic [1:0] size, input logic [AW+1:0] addr,
                                    input logic [31:0] wd);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {addr[1:0], 3'b000};
                data = {24'b0, wd[7:0]} << {addr[1:0], 3'b000};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {addr[1], 4'b0000};
                data = {16'b0, wd[15:0]} << {addr[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wd;
            end
        endcase
        ref_mem[addr[AW+1:2]] = (ref_mem[addr[AW+1:2]] & ~mask) | (data & mask);
    endfunction

    // Called right after the accepting edge: queue the predicted response and write.
    task automatic push_expect(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [AW+1:0] addr, input logic [31:0] wd);
        rsp_t r;
        wr_t  w;
        logic e;
        e = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00);
        r.acc   = cyc;
        r.err   = e;
        r.rdata = (e || we) ? 32'b0 : m_load(size, sgn, addr);
        r.lat   = e ? 1 : (!we ? 2 : (size == 2'b10 ? 2 : 3));
        rq.push_back(r);
        if (!e && we) begin
            m_store(size, addr, wd);
            w.a = addr[AW+1:2];
            w.d = ref_mem[addr[AW+1:2]];
            wq.push_back(w);
        end
    endtask

    task automatic wait_ready(output logic ok);
        int n;
        n = 0;
        while (REQ_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        ok = (REQ_READY === 1'b1);
        if (!ok) check("ready_timeout", 32'(REQ_READY), 32'(1));
    endtask

    task automatic scramble_inputs();
        REQ_WE     = 1'($urandom_range(0, 1));
        REQ_SIZE   = 2'($urandom_range(0, 3));
        REQ_SIGNED = 1'($urandom_range(0, 1));
        REQ_ADDR   = 11'($urandom);
        REQ_WDATA  = $urandom;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [AW+1:0] addr, input logic [31:0] wd);
        logic ok;
        @(negedge CLK);
        REQ_WE = we; REQ_SIZE = size; REQ_SIGNED = sgn; REQ_ADDR = addr; REQ_WDATA = wd;
        REQ_VALID = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            REQ_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        push_expect(we, size, sgn, addr, wd);
        REQ_VALID = 1'b0;
        scramble_inputs();
    endtask

    // Response and memory-write monitors.
    always @(negedge CLK) begin
        rsp_t e;
        wr_t  w;
        if (RSP_VALID === 1'b1) begin
            if (rq.size() == 0) begin
                check("unexp_rsp", 32'(RSP_VALID), 32'(0));
            end else begin
                e = rq.pop_front();
                check("rsp_rdata", RSP_RDATA, e.rdata);
                check("rsp_err", 32'(RSP_ERR), 32'(e.err));
                check("rsp_lat", 32'(cyc - e.acc + 1), 32'(e.lat));
                $display("rsp acc=%0d rdata=%08h err=%0b lat=%0d", e.acc, RSP_RDATA,
                         RSP_ERR, cyc - e.acc + 1);
            end
        end
        if (DMWE !== 2'b00) begin
            if (wq.size() == 0) begin
                check("unexp_wr", 32'(DMWE), 32'(0));
            end else begin
                w = wq.pop_front();
                check("dmwe", 32'(DMWE), 32'(2'b01));
                check("dma", 32'(DMA), 32'(w.a));
                check("dmwd", DMWD, w.d);
            end
        end else if (RST === 1'b0 && DMWD !== 32'b0) begin
            check("dmwd_idle", DMWD, 32'(0));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic ok;
        int   a1;
        int   a2;
        logic [31:0] v;

        RST = 1'b1;
        REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'b00; REQ_SIGNED = 1'b0;
        REQ_ADDR = '0; REQ_WDATA = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready", 32'(REQ_READY), 32'(0));
        check("rst_rsp_valid", 32'(RSP_VALID), 32'(0));
        check("rst_rsp_rdata", RSP_RDATA, 32'(0));
        check("rst_rsp_err", 32'(RSP_ERR), 32'(0));
        check("rst_dma", 32'(DMA), 32'(0));
        check("rst_dmwe", 32'(DMWE), 32'(0));
        check("rst_dmwd", DMWD, 32'(0));

        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       v = 32'd17;
                1:       v = 32'd31;
                2:       v = 32'hFFFF_FFFB;
                4:       v = 32'd250;
                default: v = $urandom;
            endcase
            bd_we = 1'b1; bd_addr = 9'(i); bd_data = v;
            ref_mem[i] = v;
            @(negedge CLK);
        end
        bd_we = 1'b0;
        RST = 1'b0;
        #1;
        check("ready_after_rst", 32'(REQ_READY), 32'(1));

        // Sub-word and word loads
        do_req(1'b0, 2'b00, 1'b1, 11'h010, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 11'h010, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 11'h008, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 11'h00A, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 11'h00A, 32'h0);

        // Byte store with junk in the upper data bits, then read back
        do_req(1'b1, 2'b00, 1'b0, 11'h005, 32'h5566_77AB);
        do_req(1'b0, 2'b10, 1'b0, 11'h004, 32'h0);

        // Misaligned and illegal-size requests
        do_req(1'b0, 2'b10, 1'b0, 11'h006, 32'h0);
        do_req(1'b0, 2'b11, 1'b0, 11'h000, 32'h0);
        do_req(1'b1, 2'b11, 1'b0, 11'h008, 32'hDEAD_BEEF);
        do_req(1'b1, 2'b01, 1'b0, 11'h003, 32'h0000_BEEF);

        // Reset while the half store sits in MERGE
        @(negedge CLK);
        REQ_WE = 1'b1; REQ_SIZE = 2'b01; REQ_SIGNED = 1'b0; REQ_ADDR = 11'h002;
        REQ_WDATA = 32'h0000_1234; REQ_VALID = 1'b1;
        wait_ready(ok);
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("ready_in_rst", 32'(REQ_READY), 32'(0));
        RST = 1'b0;
        #1;
        check("ready_post_abort", 32'(REQ_READY), 32'(1));
        $display("req half store @002 aborted by reset");
        repeat (4) @(posedge CLK);
        do_req(1'b0, 2'b10, 1'b0, 11'h000, 32'h0);

        // Back-to-back word stores with REQ_VALID held high
        @(negedge CLK);
        REQ_WE = 1'b1; REQ_SIZE = 2'b10; REQ_SIGNED = 1'b0; REQ_ADDR = 11'h00C;
        REQ_WDATA = 32'hCAFE_0001; REQ_VALID = 1'b1;
        wait_ready(ok);
        @(posedge CLK);
        #1;
        a1 = cyc;
        push_expect(1'b1, 2'b10, 1'b0, 11'h00C, 32'hCAFE_0001);
        REQ_WDATA = 32'h0BAD_0002;
        REQ_ADDR  = 11'h014;
        @(negedge CLK);
        wait_ready(ok);
        @(posedge CLK);
        #1;
        a2 = cyc;
        check("accept_gap", 32'(a2 - a1), 32'(3));
        push_expect(1'b1, 2'b10, 1'b0, 11'h014, 32'h0BAD_0002);
        REQ_VALID = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 11'h00C, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 11'h014, 32'h0);

        // Mixed traffic over the preloaded region
        for (int i = 0; i < 30; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 11'($urandom_range(0, 63)), $urandom);
        end

        for (int n = 0; n < 20 && (rq.size() != 0 || wq.size() != 0); n++) @(negedge CLK);
        check("rsp_q_empty", 32'(rq.size()), 32'(0));
        check("wr_q_empty", 32'(wq.size()), 32'(0));
        repeat (3) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
